// File: rtl/result_formatter.sv
// result_formatter: converts a signed two's-complement ALU result into the
// magnitude / sign / error form used by the 7-segment output driver.
// Build option: define RESULT_FORMATTER_BCD_EN to convert the magnitude to
// packed BCD with an iterative double-dabble engine (CONVERT state). Without
// it, o_data is the zero-extended binary magnitude with one-cycle latency.
module result_formatter #(
   parameter int DATA_WIDTH = 16,
   parameter int OUT_WIDTH  = 20
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] i_result,
   input  logic                  i_error,
   input  logic                  i_valid,
   output logic                  o_ready,
   output logic [OUT_WIDTH-1:0]  o_data,
   output logic                  o_error,
   output logic                  o_data_is_neg,
   output logic                  o_valid,
   input  logic                  i_ready
);

   if (DATA_WIDTH < 4 || OUT_WIDTH < DATA_WIDTH || (OUT_WIDTH % 4) != 0) begin : g_param_check
      $fatal(1, "result_formatter: illegal DATA_WIDTH/OUT_WIDTH combination");
   end

`ifdef RESULT_FORMATTER_BCD_EN
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CONVERT = 2'd1,
      OUTPUT  = 2'd2
   } state_t;
`else
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      OUTPUT  = 2'd2
   } state_t;
`endif

   state_t state;
   state_t state_next;

   logic                  in_neg;
   logic [DATA_WIDTH-1:0] mag;
   logic                  accept;

   // Sign and magnitude of the incoming result; the most negative value
   // wraps to 2^(DATA_WIDTH-1), which is the correct unsigned magnitude.
   always_comb begin
      in_neg = i_result[DATA_WIDTH-1];
      mag    = in_neg ? ((~i_result) + DATA_WIDTH'(1)) : i_result;
      accept = (state == IDLE) && i_valid;
   end

`ifdef RESULT_FORMATTER_BCD_EN
   localparam int BCD_W  = 4 * ((DATA_WIDTH + 2) / 3);
   localparam int DD_W   = BCD_W + DATA_WIDTH;
   localparam int EXT_W  = (BCD_W > OUT_WIDTH) ? BCD_W : OUT_WIDTH;
   localparam int CNT_W  = $clog2(DATA_WIDTH);

   logic [DATA_WIDTH-1:0] bin_sr;
   logic [BCD_W-1:0]      bcd_sr;
   logic [CNT_W-1:0]      cnt;
   logic [BCD_W-1:0]      bcd_adj;
   logic [DD_W-1:0]       dd_shift;
   logic [EXT_W-1:0]      bcd_ext;
   logic                  bcd_ovf;
   logic                  convert_last;

   // One double-dabble step: add 3 to every nibble >= 5, then shift the
   // combined {bcd, bin} register left by one. bcd_ext is the BCD value that
   // results from this step, padded so overflow above OUT_WIDTH is a plain OR.
   always_comb begin
      bcd_adj = bcd_sr;
      for (int unsigned i = 0; i < BCD_W / 4; i++) begin
         if (bcd_sr[4*i +: 4] >= 4'd5) begin
            bcd_adj[4*i +: 4] = bcd_sr[4*i +: 4] + 4'd3;
         end
      end
      dd_shift     = {bcd_adj, bin_sr} << 1;
      bcd_ext      = EXT_W'(dd_shift[DD_W-1:DATA_WIDTH]);
      bcd_ovf      = |(bcd_ext >> OUT_WIDTH);
      convert_last = (state == CONVERT) && (cnt == '0);
   end

   // Double-dabble shift registers and step counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bin_sr <= '0;
         bcd_sr <= '0;
         cnt    <= '0;
      end else if (accept && !i_error) begin
         bin_sr <= mag;
         bcd_sr <= '0;
         cnt    <= CNT_W'(DATA_WIDTH - 1);
      end else if (state == CONVERT) begin
         bin_sr <= dd_shift[DATA_WIDTH-1:0];
         bcd_sr <= dd_shift[DD_W-1:DATA_WIDTH];
         if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
         end
      end
   end
`endif

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic; unused encodings fall back to IDLE.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (i_valid) begin
`ifdef RESULT_FORMATTER_BCD_EN
               state_next = i_error ? OUTPUT : CONVERT;
`else
               state_next = OUTPUT;
`endif
            end
         end
`ifdef RESULT_FORMATTER_BCD_EN
         CONVERT: begin
            if (cnt == '0) begin
               state_next = OUTPUT;
            end
         end
`endif
         OUTPUT: begin
            if (i_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Output word registers; loaded on accept (and at the end of conversion
   // in the BCD build), otherwise held stable.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_data        <= '0;
         o_error       <= 1'b0;
         o_data_is_neg <= 1'b0;
      end else if (accept) begin
         if (i_error) begin
            o_data        <= '0;
            o_error       <= 1'b1;
            o_data_is_neg <= 1'b0;
         end else begin
            o_error       <= 1'b0;
            o_data_is_neg <= in_neg;
`ifdef RESULT_FORMATTER_BCD_EN
            o_data        <= '0;
`else
            o_data        <= OUT_WIDTH'(mag);
`endif
         end
      end
`ifdef RESULT_FORMATTER_BCD_EN
      else if (convert_last) begin
         if (bcd_ovf) begin
            o_data        <= '0;
            o_error       <= 1'b1;
            o_data_is_neg <= 1'b0;
         end else begin
            o_data        <= bcd_ext[OUT_WIDTH-1:0];
         end
      end
`endif
   end

   assign o_valid = (state == OUTPUT);
   assign o_ready = (state == IDLE) && rst_n;

endmodule

// File: tb/tb_result_formatter.sv
// Self-checking bench for result_formatter (DATA_WIDTH=16, OUT_WIDTH=20).
// Follows RESULT_FORMATTER_BCD_EN the same way as the design build.
module tb_result_formatter;

   localparam int DW = 16;
   localparam int OW = 20;

   logic          clk;
   logic          rst_n;
   logic [DW-1:0] i_result;
   logic          i_error;
   logic          i_valid;
   logic          o_ready;
   logic [OW-1:0] o_data;
   logic          o_error;
   logic          o_data_is_neg;
   logic          o_valid;
   logic          i_ready;

   int n_checks = 0;
   int n_fail   = 0;

   result_formatter #(
      .DATA_WIDTH(DW),
      .OUT_WIDTH (OW)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_result     (i_result),
      .i_error      (i_error),
      .i_valid      (i_valid),
      .o_ready      (o_ready),
      .o_data       (o_data),
      .o_error      (o_error),
      .o_data_is_neg(o_data_is_neg),
      .o_valid      (o_valid),
      .i_ready      (i_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct packed {
      logic [OW-1:0] data;
      logic          err;
      logic          neg;
   } item_t;

   // Formatted word from the arithmetic meaning of the input.
   function automatic item_t model_fmt(input logic [DW-1:0] r, input logic e);
      item_t it;
      int    v;
      int    m;
      it = '0;
      if (e) begin
         it.err = 1'b1;
         return it;
      end
      v      = int'($signed(r));
      it.neg = (v < 0);
      m      = it.neg ? -v : v;
`ifdef RESULT_FORMATTER_BCD_EN
      for (int d = 0; d < OW / 4; d++) begin
         it.data[4*d +: 4] = 4'(m % 10);
         m = m / 10;
      end
      if (m != 0) begin
         it     = '0;
         it.err = 1'b1;
      end
`else
      it.data = OW'(m);
`endif
      return it;
   endfunction

   // Edges from the accepting edge (inclusive) to the first cycle with o_valid.
   function automatic int model_lat(input logic e);
`ifdef RESULT_FORMATTER_BCD_EN
      return e ? 1 : DW + 1;
`else
      return 1;
`endif
   endfunction

   logic  m_busy;
   int    m_cyc;
   int    m_valid_at;
   item_t m_item;

   // Model: one outstanding word, visible from a fixed cycle after acceptance.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy <= 1'b0;
      end else begin
         m_cyc <= m_cyc + 1;
         if (m_busy && (m_cyc >= m_valid_at)) begin
            if (i_ready) m_busy <= 1'b0;
         end else if (!m_busy && i_valid) begin
            m_busy     <= 1'b1;
            m_item     <= model_fmt(i_result, i_error);
            m_valid_at <= m_cyc + model_lat(i_error);
         end
      end
   end

   // Compare process: every cycle, mid-period.
   always @(negedge clk) begin
      if (!rst_n) begin
         check("rst_o_valid", {31'd0, o_valid}, 32'd0);
         check("rst_o_ready", {31'd0, o_ready}, 32'd0);
         check("rst_o_data", {12'd0, o_data}, 32'd0);
         check("rst_o_error", {31'd0, o_error}, 32'd0);
         check("rst_o_neg", {31'd0, o_data_is_neg}, 32'd0);
      end else begin
         check("cyc_o_valid", {31'd0, o_valid}, {31'd0, m_busy && (m_cyc >= m_valid_at)});
         check("cyc_o_ready", {31'd0, o_ready}, {31'd0, !m_busy});
         if (m_busy && (m_cyc >= m_valid_at)) begin
            check("cyc_o_data", {12'd0, o_data}, {12'd0, m_item.data});
            check("cyc_o_error", {31'd0, o_error}, {31'd0, m_item.err});
            check("cyc_o_neg", {31'd0, o_data_is_neg}, {31'd0, m_item.neg});
         end
      end
   end

   // ---------------- directed stimulus ----------------
   // Sends one word, checks hand-computed literal results and latency, and
   // optionally completes the transfer.
   task automatic send(input logic [DW-1:0] r, input logic e,
                       input logic [OW-1:0] exp_hex, input logic [OW-1:0] exp_bcd,
                       input logic exp_neg, input logic exp_err, input bit complete);
      int lat;
      int exp_lat;
      logic [OW-1:0] exp_d;
`ifdef RESULT_FORMATTER_BCD_EN
      exp_d   = exp_bcd;
      exp_lat = e ? 1 : 17;
`else
      exp_d   = exp_hex;
      exp_lat = 1;
`endif
      check("pre_ready", {31'd0, o_ready}, 32'd1);
      i_result = r;
      i_error  = e;
      i_valid  = 1'b1;
      @(posedge clk);
      #2;
      i_valid = 1'b0;
      i_error = 1'b0;
      lat = 1;
      while (!o_valid && lat < 60) begin
         @(posedge clk);
         #2;
         lat++;
      end
      check("latency", lat, exp_lat);
      check("lit_data", {12'd0, o_data}, {12'd0, exp_d});
      check("lit_neg", {31'd0, o_data_is_neg}, {31'd0, exp_neg});
      check("lit_err", {31'd0, o_error}, {31'd0, exp_err});
      if (complete) begin
         i_ready = 1'b1;
         @(posedge clk);
         #2;
         i_ready = 1'b0;
         check("post_valid", {31'd0, o_valid}, 32'd0);
         check("post_ready", {31'd0, o_ready}, 32'd1);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n    = 1'b1;
      i_result = '0;
      i_error  = 1'b0;
      i_valid  = 1'b0;
      i_ready  = 1'b0;
      m_cyc    = 0;
      m_valid_at = 0;
      m_item   = '0;
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      check("reset_ready", {31'd0, o_ready}, 32'd0);
      check("reset_data", {12'd0, o_data}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #2;

      //    input     err  hex         bcd         neg  err  complete
      send(16'hFFFE, 1'b0, 20'h00002, 20'h00002, 1'b1, 1'b0, 1'b1);
      send(16'h3039, 1'b0, 20'h03039, 20'h12345, 1'b0, 1'b0, 1'b1);
      send(16'h8000, 1'b0, 20'h08000, 20'h32768, 1'b1, 1'b0, 1'b1);
      send(16'h0000, 1'b0, 20'h00000, 20'h00000, 1'b0, 1'b0, 1'b1);
      send(16'h1234, 1'b1, 20'h00000, 20'h00000, 1'b0, 1'b1, 1'b1);
      send(16'h7FFF, 1'b0, 20'h07FFF, 20'h32767, 1'b0, 1'b0, 1'b1);
      send(16'hFFFF, 1'b0, 20'h00001, 20'h00001, 1'b1, 1'b0, 1'b1);
      send(16'hD8F1, 1'b0, 20'h0270F, 20'h09999, 1'b1, 1'b0, 1'b1);

      // Backpressure: word held while new inputs are offered and ignored.
      send(16'hFFF9, 1'b0, 20'h00007, 20'h00007, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         i_result = 16'h1111;
         i_valid  = (i % 2 == 0);
         @(posedge clk);
         #2;
         check("bp_ready", {31'd0, o_ready}, 32'd0);
         check("bp_valid", {31'd0, o_valid}, 32'd1);
         check("bp_data", {12'd0, o_data}, 32'h00000007);
         check("bp_neg", {31'd0, o_data_is_neg}, 32'd1);
      end
      i_valid = 1'b0;
      i_ready = 1'b1;
      @(posedge clk);
      #2;
      i_ready = 1'b0;
      check("bp_done_valid", {31'd0, o_valid}, 32'd0);
      check("bp_done_ready", {31'd0, o_ready}, 32'd1);

      // Reset while the word is in flight (mid-conversion in the BCD build).
      i_result = 16'h3039;
      i_valid  = 1'b1;
      @(posedge clk);
      #2;
      i_valid = 1'b0;
      repeat (8) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_valid", {31'd0, o_valid}, 32'd0);
      check("midrst_data", {12'd0, o_data}, 32'd0);
      check("midrst_ready", {31'd0, o_ready}, 32'd0);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      #1;
      check("rel_ready", {31'd0, o_ready}, 32'd1);
      @(posedge clk);
      #2;
      send(16'h0001, 1'b0, 20'h00001, 20'h00001, 1'b0, 1'b0, 1'b1);

      repeat (3) @(posedge clk);
      #2;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
